// File: rtl/wb_arbiter.sv
// Write-port arbiter for the integer register file: merges ALU and LSU results,
// bounds LSU starvation, and tracks pending long-latency destinations.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  output logic        alu_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [63:0] lsu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_pending,
  output logic        rs2_pending,
  output logic        write_enable,
  output logic [4:0]  rd_addr,
  output logic [63:0] rd_data
);

  logic [3:0]  starve_cnt;
  logic [31:0] pend_mask;
  logic [31:0] pend_mask_nxt;
  logic        wr_from_lsu;
  logic        alu_grant;
  logic        lsu_hs;

  // Stall decodes only registered state, so it never loops back through the inputs.
  assign alu_stall = (starve_cnt == 4'(STARVE_LIMIT));
  assign alu_grant = alu_valid & ~alu_stall;
  assign lsu_ready = ~alu_valid | alu_stall;
  assign lsu_hs    = lsu_valid & lsu_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_enable <= 1'b0;
      wr_from_lsu  <= 1'b0;
      rd_addr      <= '0;
      rd_data      <= '0;
    end else if (alu_grant) begin
      write_enable <= (alu_rd != 5'd0);
      wr_from_lsu  <= 1'b0;
      rd_addr      <= alu_rd;
      rd_data      <= alu_data;
    end else if (lsu_hs) begin
      write_enable <= (lsu_rd != 5'd0);
      wr_from_lsu  <= 1'b1;
      rd_addr      <= lsu_rd;
      rd_data      <= lsu_data;
    end else begin
      write_enable <= 1'b0;
      wr_from_lsu  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (!lsu_valid || lsu_hs)
      starve_cnt <= '0;
    else if (alu_grant && !alu_stall)
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Clear first, then set, so a re-issue on the retiring edge keeps the bit.
  always_comb begin
    pend_mask_nxt = pend_mask;
    if (write_enable && wr_from_lsu)
      pend_mask_nxt[rd_addr] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0))
      pend_mask_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      pend_mask <= '0;
    else
      pend_mask <= pend_mask_nxt;
  end

  assign rs1_pending = pend_mask[rs1_addr];
  assign rs2_pending = pend_mask[rs2_addr];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written
// starvation/reset sequences, then random traffic against a cycle model.
module tb_wb_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1_addr, rs2_addr;
  logic [63:0] alu_data, lsu_data;
  logic        alu_stall, lsu_ready, rs1_pending, rs2_pending, write_enable;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .write_enable(write_enable), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  typedef struct {
    logic        av;  logic [4:0] ard; logic [63:0] adat;
    logic        lv;  logic [4:0] lrd; logic [63:0] ldat;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        we;  logic [4:0] rd;  logic [63:0] dat; logic ck;
    logic        rdy; logic st;  logic p1;  logic p2;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    issue_valid = iv; issue_rd = ird;
    rs1_addr = r1; rs2_addr = r2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // The upstream contract forbids ALU results while stalled.
  always @(posedge clk)
    if (rst_n && alu_valid && alu_stall) begin
      n_fail++;
      $display("FAIL protocol: alu_valid asserted while alu_stall at %0t", $time);
    end

  // Random-phase reference model state.
  logic        m_we, m_lsu, l_hold, lv_r, av_r, iv_r, st_e, rdy_e, win_a, hs;
  logic [4:0]  m_rd, l_rd, a_rd, i_rd, r1_r, r2_r;
  logic [63:0] m_dat, l_dat, a_dat;
  logic [31:0] m_mask;
  int          m_blk;

  initial begin
    tbl[0]  = '{1'b1,5'd5,64'hAAAA, 1'b1,5'd6,64'h1234, 1'b0,5'd0, 5'd0,5'd0, 1'b0,5'd0,64'h0,1'b1,    1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,5'd0,64'h0,    1'b1,5'd6,64'h1234, 1'b0,5'd0, 5'd0,5'd0, 1'b1,5'd5,64'hAAAA,1'b1, 1'b1,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b1,5'd6,64'h1234,1'b1, 1'b1,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b0,5'd0, 5'd0,5'd0, 1'b0,5'd6,64'h1234,1'b1, 1'b1,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b1,5'd7, 5'd7,5'd0, 1'b0,5'd6,64'h1234,1'b1, 1'b1,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b0,5'd6,64'h1234,1'b1, 1'b1,1'b0,1'b1,1'b0};
    tbl[6]  = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b0,5'd6,64'h1234,1'b1, 1'b1,1'b0,1'b1,1'b0};
    tbl[7]  = '{1'b0,5'd0,64'h0,    1'b1,5'd7,64'h55,   1'b0,5'd0, 5'd7,5'd0, 1'b0,5'd6,64'h1234,1'b1, 1'b1,1'b0,1'b1,1'b0};
    tbl[8]  = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b1,5'd7,64'h55,1'b1,   1'b1,1'b0,1'b1,1'b0};
    tbl[9]  = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b0,5'd7,64'h55,1'b1,   1'b1,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,5'd0,64'h0,    1'b1,5'd7,64'h66,   1'b1,5'd7, 5'd7,5'd0, 1'b0,5'd7,64'h55,1'b1,   1'b1,1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b1,5'd7, 5'd7,5'd0, 1'b1,5'd7,64'h66,1'b1,   1'b1,1'b0,1'b1,1'b0};
    tbl[12] = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b0,5'd0, 5'd7,5'd0, 1'b0,5'd7,64'h66,1'b1,   1'b1,1'b0,1'b1,1'b0};
    tbl[13] = '{1'b0,5'd0,64'h0,    1'b1,5'd0,64'hDEAD, 1'b1,5'd0, 5'd0,5'd7, 1'b0,5'd7,64'h66,1'b1,   1'b1,1'b0,1'b0,1'b1};
    tbl[14] = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b0,5'd0, 5'd0,5'd7, 1'b0,5'd0,64'h0,1'b0,    1'b1,1'b0,1'b0,1'b1};
    tbl[15] = '{1'b0,5'd0,64'h0,    1'b0,5'd0,64'h0,    1'b0,5'd0, 5'd0,5'd7, 1'b0,5'd0,64'h0,1'b0,    1'b1,1'b0,1'b0,1'b1};

    // Reset with inputs toggling.
    rst_n = 1'b0;
    idle();
    repeat (2) begin
      @(negedge clk);
      drive($urandom_range(0,1), 5'($urandom), {$urandom(), $urandom()},
            $urandom_range(0,1), 5'($urandom), {$urandom(), $urandom()},
            $urandom_range(0,1), 5'($urandom), 5'($urandom), 5'($urandom));
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    chk("reset write_enable", write_enable, 0);
    chk("reset alu_stall", alu_stall, 0);
    chk("reset rd_addr", rd_addr, 0);
    chk("reset rd_data", rd_data, 0);
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i);
      #1;
      chk("reset rs1_pending", rs1_pending, 0);
      chk("reset rs2_pending", rs2_pending, 0);
    end

    // Directed table: conflict, scoreboard, x0.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].lv, tbl[i].lrd, tbl[i].ldat,
            tbl[i].iv, tbl[i].ird, tbl[i].r1, tbl[i].r2);
      #1;
      chk($sformatf("vec%0d write_enable", i), write_enable, tbl[i].we);
      if (tbl[i].ck) begin
        chk($sformatf("vec%0d rd_addr", i), rd_addr, tbl[i].rd);
        chk($sformatf("vec%0d rd_data", i), rd_data, tbl[i].dat);
      end
      chk($sformatf("vec%0d lsu_ready", i), lsu_ready, tbl[i].rdy);
      chk($sformatf("vec%0d alu_stall", i), alu_stall, tbl[i].st);
      chk($sformatf("vec%0d rs1_pending", i), rs1_pending, tbl[i].p1);
      chk($sformatf("vec%0d rs2_pending", i), rs2_pending, tbl[i].p2);
    end

    // Starvation: LSU blocked cycles 0..3, stall and handshake in cycle 4.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(k != 4, 5'd11, 64'(k), k <= 4, 5'd10, 64'hBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      chk($sformatf("starve%0d alu_stall", k), alu_stall, k == 4);
      chk($sformatf("starve%0d lsu_ready", k), lsu_ready, k == 4);
      chk($sformatf("starve%0d write_enable", k), write_enable, k != 0);
      if (k >= 1 && k <= 4) begin
        chk($sformatf("starve%0d rd_addr", k), rd_addr, 11);
        chk($sformatf("starve%0d rd_data", k), rd_data, 64'(k - 1));
      end else if (k == 5) begin
        chk("starve5 rd_addr", rd_addr, 10);
        chk("starve5 rd_data", rd_data, 64'hBEEF);
      end else if (k >= 6) begin
        chk($sformatf("starve%0d rd_addr", k), rd_addr, 11);
        chk($sformatf("starve%0d rd_data", k), rd_data, 64'(k - 1));
      end
    end

    // Reset mid-flight with pending bits {3,9} and an LSU result offered.
    @(negedge clk); drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3, 5'd9);
    @(negedge clk); drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd3, 5'd9);
    @(negedge clk); drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd9);
    #1;
    chk("midrst pre p3", rs1_pending, 1);
    chk("midrst pre p9", rs2_pending, 1);
    @(negedge clk);
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h77, 1'b0, 5'd0, 5'd3, 5'd9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd9);
    #1;
    chk("midrst write_enable", write_enable, 0);
    chk("midrst p3", rs1_pending, 0);
    chk("midrst p9", rs2_pending, 0);
    @(negedge clk);
    #1;
    chk("midrst write_enable+1", write_enable, 0);

    // Random traffic against the model, starting from a clean reset.
    @(negedge clk);
    rst_n = 1'b0; idle();
    @(negedge clk);
    rst_n = 1'b1;
    m_we = 0; m_lsu = 0; m_rd = 0; m_dat = 0; m_mask = 0; m_blk = 0; l_hold = 0;
    l_rd = 0; l_dat = 0; lv_r = 0;
    for (int c = 0; c < 600; c++) begin
      if (c != 0) @(negedge clk);
      st_e = (m_blk >= LIM);
      av_r = st_e ? 1'b0 : ($urandom_range(0, 3) != 0);
      a_rd = 5'($urandom_range(0, 7));
      a_dat = {$urandom(), $urandom()};
      if (!l_hold) begin
        lv_r  = $urandom_range(0, 1);
        l_rd  = 5'($urandom_range(0, 7));
        l_dat = {$urandom(), $urandom()};
      end
      iv_r = $urandom_range(0, 2) == 0;
      i_rd = 5'($urandom_range(0, 7));
      r1_r = 5'($urandom_range(0, 7));
      r2_r = 5'($urandom_range(0, 7));
      drive(av_r, a_rd, a_dat, lv_r, l_rd, l_dat, iv_r, i_rd, r1_r, r2_r);
      #1;
      rdy_e = !av_r || st_e;
      win_a = av_r && !st_e;
      hs    = lv_r && rdy_e;
      chk("rand write_enable", write_enable, m_we);
      if (m_we) begin
        chk("rand rd_addr", rd_addr, m_rd);
        chk("rand rd_data", rd_data, m_dat);
      end
      chk("rand alu_stall", alu_stall, st_e);
      chk("rand lsu_ready", lsu_ready, rdy_e);
      chk("rand rs1_pending", rs1_pending, m_mask[r1_r]);
      chk("rand rs2_pending", rs2_pending, m_mask[r2_r]);
      @(posedge clk);
      if (m_we && m_lsu) m_mask[m_rd] = 1'b0;
      if (iv_r && i_rd != 0) m_mask[i_rd] = 1'b1;
      if (win_a) begin
        m_we = (a_rd != 0); m_lsu = 0; m_rd = a_rd; m_dat = a_dat;
      end else if (hs) begin
        m_we = (l_rd != 0); m_lsu = 1; m_rd = l_rd; m_dat = l_dat;
      end else begin
        m_we = 0; m_lsu = 0;
      end
      m_blk  = (lv_r && !hs) ? ((m_blk < LIM) ? m_blk + 1 : LIM) : 0;
      l_hold = lv_r && !hs;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
